nn_inst_issuer: RTL and testbench
=================================

// Module: nn_inst_issuer
// PURPOSE
//  Host-side producer of 31-bit NN micro-op words for the NNTop instruction FIFO.
//  - Takes one command descriptor: submod, opcode, config, base address, repeat count, address stride.
//  - Expands it into a burst of micro-ops and writes them into the instruction FIFO.
//  - Writes stall while the FIFO reports full.
//  - Sits between the host command port and the instfifo write side; the top controller consumes the words.
// PARAMETERS
//  GLB_ADDR_WIDTH  16  base-address field width; address arithmetic wraps modulo 2^GLB_ADDR_WIDTH
//  CNT_WIDTH        8  width of repeat count and of the per-burst remaining counter
//  STAT_WIDTH      16  width of the running issued-word statistic counter
// PORTS
//  clk           in   1   single clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  en            in   1   global enable; when low, all state and the write strobe freeze
//  cmd_valid     in   1   command descriptor valid
//  cmd_ready     out  1   issuer idle and able to accept a descriptor
//  cmd_submod    in   3   micro-op submodule field
//  cmd_opcode    in   4   micro-op opcode field
//  cmd_config    in   6   micro-op config field
//  cmd_baseaddr  in   GLB_ADDR_WIDTH  address of the first word
//  cmd_count     in   CNT_WIDTH       number of words to emit; 0 means none
//  cmd_stride    in   GLB_ADDR_WIDTH  address increment between successive words
//  cmd_wb        in   1   request a trailing CTRL_WB word (only with NN_ISSUER_WB_APPEND_EN)
//  inst_out      out  31  micro-op word: [30:28] submod, [27:24] opcode, [23:18] config, [17:16] 2'b00, [15:0] baseaddr
//  instfifo_write out 1   write strobe into the instruction FIFO
//  instfifo_full in   1   instruction FIFO full
//  busy          out  1   high from the cycle after acceptance until the burst completes
//  done          out  1   one-cycle pulse when the burst completes
//  issued_total  out  STAT_WIDTH  running count of words written; wraps
// BEHAVIOUR
//  Reset (async): state IDLE; busy=0, done=0, instfifo_write=0, inst_out=0, issued_total=0, counters=0.
//  Reset mid-burst: the rest of the burst is dropped; words already written stay in the FIFO.
//  FSM states: IDLE, ISSUE, TAIL, FIN.
//   IDLE -> ISSUE  on cmd_valid && cmd_ready && cmd_count!=0; latch fields; rem=cmd_count; addr=cmd_baseaddr.
//   IDLE -> FIN    on acceptance with cmd_count==0; no word is written.
//   ISSUE          on each write: addr <= addr+cmd_stride (wraps); rem <= rem-1.
//                  On the write with rem==1, go to TAIL if a tail word is pending, otherwise to FIN.
//   TAIL           writes one CTRL_WB word (submod CTRL, opcode CTRL_WB, config 0, addr 0), then goes to FIN.
//   FIN            done=1 for exactly one cycle, then IDLE.
//  Outputs:
//   cmd_ready  = (state==IDLE) && en.
//   busy       = state != IDLE.
//   instfifo_write = en && !instfifo_full && state in {ISSUE, TAIL}. Combinational; no word is written while full.
//   inst_out   combinational from latched fields and the current addr; stable while stalled.
//   issued_total increments by 1 on every instfifo_write (tail word included).
//  Boundary conditions:
//   - instfifo_full asserted for N cycles: the burst stretches by N cycles; word contents and order are unchanged.
//   - cmd_valid while busy: ignored (cmd_ready=0); the descriptor must be held until accepted.
//   - Address wrap: 0xFFFF + stride 2 -> 0x0001.
//   - cmd_count=2^CNT_WIDTH-1 is the maximum burst length.
// CONFIGURATION
//  `NN_ISSUER_WB_APPEND_EN defined: cmd_wb is latched at acceptance; the TAIL state is reachable;
//     with cmd_count==0 and cmd_wb==1 the issuer goes IDLE->TAIL, so exactly one CTRL_WB word is written.
//  Macro undefined: cmd_wb is ignored; TAIL is never entered and its logic is absent; bursts contain only body words.
// STRUCTURE
//  Shared header nn_microops.v: NNMICROOPS_* field MSB/LSB positions, SUBMOD codes, OPCODE_CTRL_WB,
//    OPCODE_SET, OPCODE_CTRL_OEN. The word layout must come only from these macros; no literals here.
//  Local parameters: state encodings.
//  Sub-module nn_inst_pack: combinational packing of the fields into the 31-bit word.
//    Shared with other micro-op producers.
//  Everything else (FSM, address/remaining counters, stats) is flat in this module.
// TESTING
//  1. Burst: submod=CONV, opcode=0, base=0x0100, count=4, stride=0x10, FIFO never full
//       -> 4 consecutive writes, addr 0x0100/0x0110/0x0120/0x0130; done 1 cycle after the last write;
//          issued_total=4.
//  2. Backpressure: as test 1, instfifo_full high for 3 cycles after the 2nd write
//       -> no write during full; words 3-4 follow unchanged; burst takes 7 cycles.
//  3. Zero count: count=0 accepted -> no instfifo_write; done pulses; cmd_ready is back 2 cycles after acceptance.
//  4. Wrap: base=0xFFFE, stride=1, count=3 -> addr 0xFFFE, 0xFFFF, 0x0000.
//  5. Reset after the 2nd of 5 words: reset_n low -> outputs 0 immediately; after release a new command is accepted.
//  6. Tail (macro on): count=2, cmd_wb=1 -> 2 body words, then word {CTRL,CTRL_WB,0,0}; issued_total=3.
//     Macro off: only 2 words.

Source files
------------

// File: rtl/nn_inst_issuer_pkg.sv
// nn_inst_issuer_pkg: micro-op word layout, submodule/opcode codes and issuer state encoding.
package nn_inst_issuer_pkg;
    localparam int NNMICROOPS_INST_WIDTH = 31;
    localparam int NNMICROOPS_SUBMOD_MSB = 30;
    localparam int NNMICROOPS_SUBMOD_LSB = 28;
    localparam int NNMICROOPS_OPCODE_MSB = 27;
    localparam int NNMICROOPS_OPCODE_LSB = 24;
    localparam int NNMICROOPS_CONFIG_MSB = 23;
    localparam int NNMICROOPS_CONFIG_LSB = 18;
    localparam int NNMICROOPS_ADDR_MSB   = 15;
    localparam int NNMICROOPS_ADDR_LSB   = 0;

    localparam int SUBMOD_W = NNMICROOPS_SUBMOD_MSB - NNMICROOPS_SUBMOD_LSB + 1;
    localparam int OPCODE_W = NNMICROOPS_OPCODE_MSB - NNMICROOPS_OPCODE_LSB + 1;
    localparam int CONFIG_W = NNMICROOPS_CONFIG_MSB - NNMICROOPS_CONFIG_LSB + 1;
    localparam int ADDR_W   = NNMICROOPS_ADDR_MSB - NNMICROOPS_ADDR_LSB + 1;

    localparam logic [SUBMOD_W-1:0] SUBMOD_CTRL = 3'd0;
    localparam logic [SUBMOD_W-1:0] SUBMOD_CONV = 3'd1;
    localparam logic [SUBMOD_W-1:0] SUBMOD_POOL = 3'd2;
    localparam logic [SUBMOD_W-1:0] SUBMOD_ACT  = 3'd3;

    localparam logic [OPCODE_W-1:0] OPCODE_CTRL_WB  = 4'd1;
    localparam logic [OPCODE_W-1:0] OPCODE_SET      = 4'd2;
    localparam logic [OPCODE_W-1:0] OPCODE_CTRL_OEN = 4'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_TAIL, ST_FIN} state_t;
endpackage

// File: rtl/nn_inst_issuer_if.sv
// nn_inst_issuer_if: host command port plus instruction-FIFO write side of the issuer.
interface nn_inst_issuer_if
    import nn_inst_issuer_pkg::*;
#(
    parameter int GLB_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH      = 8
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [SUBMOD_W-1:0]              cmd_submod;
    logic [OPCODE_W-1:0]              cmd_opcode;
    logic [CONFIG_W-1:0]              cmd_config;
    logic [GLB_ADDR_WIDTH-1:0]        cmd_baseaddr;
    logic [CNT_WIDTH-1:0]             cmd_count;
    logic [GLB_ADDR_WIDTH-1:0]        cmd_stride;
    logic                             cmd_wb;
    logic [NNMICROOPS_INST_WIDTH-1:0] inst_out;
    logic                             instfifo_write;
    logic                             instfifo_full;

    modport slave (
        input  cmd_valid, cmd_submod, cmd_opcode, cmd_config, cmd_baseaddr,
               cmd_count, cmd_stride, cmd_wb, instfifo_full,
        output cmd_ready, inst_out, instfifo_write
    );
    modport master (
        output cmd_valid, cmd_submod, cmd_opcode, cmd_config, cmd_baseaddr,
               cmd_count, cmd_stride, cmd_wb, instfifo_full,
        input  cmd_ready, inst_out, instfifo_write
    );
endinterface

// File: rtl/nn_inst_pack.sv
// nn_inst_pack: packs micro-op fields into the 31-bit instruction word; reserved bits stay zero.
module nn_inst_pack
    import nn_inst_issuer_pkg::*;
(
    input  logic [SUBMOD_W-1:0]              submod,
    input  logic [OPCODE_W-1:0]              opcode,
    input  logic [CONFIG_W-1:0]              cfg,
    input  logic [ADDR_W-1:0]                addr,
    output logic [NNMICROOPS_INST_WIDTH-1:0] inst
);
    always_comb begin
        inst = '0;
        inst[NNMICROOPS_SUBMOD_MSB:NNMICROOPS_SUBMOD_LSB] = submod;
        inst[NNMICROOPS_OPCODE_MSB:NNMICROOPS_OPCODE_LSB] = opcode;
        inst[NNMICROOPS_CONFIG_MSB:NNMICROOPS_CONFIG_LSB] = cfg;
        inst[NNMICROOPS_ADDR_MSB:NNMICROOPS_ADDR_LSB]     = addr;
    end
endmodule

// File: rtl/nn_inst_issuer.sv
// nn_inst_issuer: expands one command descriptor into a burst of micro-ops for the instruction FIFO.
// Define NN_ISSUER_WB_APPEND_EN to enable the optional trailing CTRL_WB word.
module nn_inst_issuer
    import nn_inst_issuer_pkg::*;
#(
    parameter int GLB_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH      = 8,
    parameter int STAT_WIDTH     = 16
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    nn_inst_issuer_if.slave       bus,
    output logic                  busy,
    output logic                  done,
    output logic [STAT_WIDTH-1:0] issued_total
);
    state_t                    state, state_d, burst_end, zero_next;
    logic [CNT_WIDTH-1:0]      rem;
    logic [GLB_ADDR_WIDTH-1:0] addr, stride;
    logic [SUBMOD_W-1:0]       submod;
    logic [OPCODE_W-1:0]       opcode;
    logic [CONFIG_W-1:0]       cfg;
    logic                      wr, accept, in_tail;

`ifdef NN_ISSUER_WB_APPEND_EN
    logic wb_pend;
    assign burst_end = wb_pend ? ST_TAIL : ST_FIN;
    assign zero_next = bus.cmd_wb ? ST_TAIL : ST_FIN;
    assign in_tail   = state == ST_TAIL;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wb_pend <= 1'b0;
        else if (en && accept) wb_pend <= bus.cmd_wb;
`else
    assign burst_end = ST_FIN;
    assign zero_next = ST_FIN;
    assign in_tail   = 1'b0;
`endif

    assign bus.cmd_ready      = state == ST_IDLE && en;
    assign accept             = bus.cmd_ready && bus.cmd_valid;
    assign bus.instfifo_write = wr;
    assign busy               = state != ST_IDLE;
    assign done               = state == ST_FIN;

    always_comb begin
        state_d = state;
        wr      = 1'b0;
        if (en)
            case (state)
                ST_IDLE:  if (accept) state_d = bus.cmd_count != '0 ? ST_ISSUE : zero_next;
                ST_ISSUE: begin
                    wr = !bus.instfifo_full;
                    if (wr && rem == CNT_WIDTH'(1)) state_d = burst_end;
                end
`ifdef NN_ISSUER_WB_APPEND_EN
                ST_TAIL: begin
                    wr = !bus.instfifo_full;
                    if (wr) state_d = ST_FIN;
                end
`endif
                default:  state_d = ST_IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state        <= ST_IDLE;
            rem          <= '0;
            addr         <= '0;
            stride       <= '0;
            submod       <= '0;
            opcode       <= '0;
            cfg          <= '0;
            issued_total <= '0;
        end else if (en) begin
            state <= state_d;
            if (accept) begin
                rem    <= bus.cmd_count;
                addr   <= bus.cmd_baseaddr;
                stride <= bus.cmd_stride;
                submod <= bus.cmd_submod;
                opcode <= bus.cmd_opcode;
                cfg    <= bus.cmd_config;
            end else if (wr && state == ST_ISSUE) begin
                addr <= addr + stride;
                rem  <= rem - 1'b1;
            end
            if (wr) issued_total <= issued_total + 1'b1;
        end

    // The tail word overrides every field with the fixed CTRL_WB encoding.
    nn_inst_pack u_pack (
        .submod (in_tail ? SUBMOD_CTRL : submod),
        .opcode (in_tail ? OPCODE_CTRL_WB : opcode),
        .cfg    (in_tail ? '0 : cfg),
        .addr   (in_tail ? '0 : ADDR_W'(addr)),
        .inst   (bus.inst_out)
    );
endmodule

// File: tb/tb_nn_inst_issuer.sv
// tb_nn_inst_issuer: scoreboard bench for nn_inst_issuer; tail expectations follow NN_ISSUER_WB_APPEND_EN.
module tb_nn_inst_issuer;
    import nn_inst_issuer_pkg::*;

`ifdef NN_ISSUER_WB_APPEND_EN
    localparam int TL = 1;
`else
    localparam int TL = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, en, busy, done;
    logic [15:0] issued_total;
    int          n_chk = 0, n_err = 0, pcyc = 0, t0 = 0, exp_total = 0;
    logic [30:0] q[$];

    nn_inst_issuer_if #(.GLB_ADDR_WIDTH(16), .CNT_WIDTH(8)) bus ();

    nn_inst_issuer #(.GLB_ADDR_WIDTH(16), .CNT_WIDTH(8), .STAT_WIDTH(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .issued_total (issued_total)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] word(input logic [2:0] sm, input logic [3:0] op,
                                         input logic [5:0] cf, input logic [15:0] a);
        return {sm, op, cf, 2'b00, a};
    endfunction

    always @(negedge clk)
        if (reset_n && bus.instfifo_write) begin
            chk("write_while_full", bus.instfifo_full, 0);
            if (q.size() != 0) chk("sb_word", bus.inst_out, q.pop_front());
            else chk("extra_word", bus.inst_out, 'x);
        end

    task automatic send_cmd(input logic [2:0] sm, input logic [3:0] op, input logic [5:0] cf,
                            input logic [15:0] base, input logic [7:0] cnt,
                            input logic [15:0] st, input logic wb);
        logic [15:0] a = base;
        int i = 0;
        @(negedge clk);
        while (!bus.cmd_ready && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (i == 400) chk("ready_timeout", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_submod = sm; bus.cmd_opcode = op; bus.cmd_config = cf;
        bus.cmd_baseaddr = base; bus.cmd_count = cnt; bus.cmd_stride = st; bus.cmd_wb = wb;
        for (int k = 0; k < int'(cnt); k++) begin
            q.push_back(word(sm, op, cf, a));
            a = a + st;
        end
        if (wb && TL == 1) q.push_back(word(SUBMOD_CTRL, OPCODE_CTRL_WB, 6'd0, 16'd0));
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        t0 = pcyc;
    endtask

    task automatic finish_burst(input string tag, input int exp_lat, input int add);
        int lat = -1;
        for (int i = 0; i < 400 && lat < 0; i++) begin
            @(negedge clk);
            if (done) lat = pcyc - t0 + 1;
        end
        bus.cmd_valid = 1'b0;
        exp_total += add;
        chk({tag, "_latency"}, lat, exp_lat);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_back"}, bus.cmd_ready, 1);
        chk({tag, "_issued_total"}, issued_total, exp_total);
        chk({tag, "_sb_drained"}, q.size(), 0);
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1;
        bus.cmd_valid = 0; bus.cmd_submod = 0; bus.cmd_opcode = 0; bus.cmd_config = 0;
        bus.cmd_baseaddr = 0; bus.cmd_count = 0; bus.cmd_stride = 0; bus.cmd_wb = 0;
        bus.instfifo_full = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write", bus.instfifo_write, 0);
        chk("rst_inst", bus.inst_out, 0);
        chk("rst_total", issued_total, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 1);

        // Basic burst; a second descriptor held valid while busy must be ignored.
        send_cmd(SUBMOD_CONV, 4'd0, 6'd0, 16'h0100, 8'd4, 16'h0010, 1'b0);
        @(negedge clk);
        chk("busy_ready", bus.cmd_ready, 0);
        chk("busy_flag", busy, 1);
        bus.cmd_valid = 1'b1; bus.cmd_count = 8'd7;
        finish_burst("burst", 5, 4);

        send_cmd(SUBMOD_CONV, 4'd0, 6'd0, 16'h0100, 8'd4, 16'h0010, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 bus.instfifo_full = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.instfifo_full = 1'b0;
        finish_burst("stall", 8, 4);

        send_cmd(SUBMOD_POOL, OPCODE_SET, 6'h2A, 16'h1234, 8'd0, 16'h0001, 1'b0);
        finish_burst("zero", 1, 0);

        send_cmd(SUBMOD_ACT, 4'd5, 6'h3F, 16'hFFFE, 8'd3, 16'h0001, 1'b0);
        finish_burst("wrap1", 4, 3);

        send_cmd(SUBMOD_CONV, 4'd9, 6'h11, 16'hFFFF, 8'd2, 16'h0002, 1'b0);
        finish_burst("wrap2", 3, 2);

        send_cmd(SUBMOD_ACT, 4'd3, 6'h05, 16'h0040, 8'd3, 16'h0004, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 en = 1'b0;
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
        finish_burst("enable", 6, 3);

        send_cmd(SUBMOD_CONV, 4'd2, 6'h01, 16'h0200, 8'd2, 16'h0008, 1'b1);
        finish_burst("tail", 3 + TL, 2 + TL);

        send_cmd(SUBMOD_CONV, 4'd2, 6'h01, 16'h0200, 8'd0, 16'h0008, 1'b1);
        finish_burst("tail_only", 1 + TL, TL);

        send_cmd(SUBMOD_POOL, 4'd7, 6'h10, 16'h1234, 8'd255, 16'h0003, 1'b0);
        finish_burst("max_count", 256, 255);

        // Reset in the middle of a burst drops the remaining words.
        send_cmd(SUBMOD_CONV, 4'd1, 6'h02, 16'h0800, 8'd5, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_write", bus.instfifo_write, 0);
        chk("midrst_inst", bus.inst_out, 0);
        chk("midrst_total", issued_total, 0);
        chk("midrst_dropped", q.size(), 3);
        q.delete();
        exp_total = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send_cmd(SUBMOD_ACT, 4'd4, 6'h07, 16'h00AA, 8'd1, 16'h0001, 1'b0);
        finish_burst("post_rst", 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
